// File: rtl/axi_write_slave.sv
// axi_write_slave: single-burst AXI write responder in front of a synchronous
// SRAM-style port. Each accepted W beat becomes one byte-enabled memory write,
// and one B response is returned per burst.
// Optional feature macro: WSLV_RANGE_CHECK_EN (out-of-range bursts get DECERR).

module axi_write_slave #(
    parameter int ID_BITS       = 8,
    parameter int ADDR_BITS     = 32,
    parameter int DATA_BITS     = 32,
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [ID_BITS-1:0]       AWID,
    input  logic [ADDR_BITS-1:0]     AWADDR,
    input  logic [3:0]               AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_BITS-1:0]     WDATA,
    input  logic [DATA_BITS/8-1:0]   WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [ID_BITS-1:0]       BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic                     mem_cs,
    output logic [DATA_BITS/8-1:0]   mem_we,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0]     mem_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, next_state;

    logic [ID_BITS-1:0]   id_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] step;
    logic [3:0]           len_q;
    logic [3:0]           beat_q;
    logic [2:0]           size_q;
    logic                 incr_q;
    logic                 ok_q;
    logic                 oor_q;
    logic                 err_q;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic final_beat;
    logic wlast_bad;
    logic aw_oor;

    assign aw_hs      = AWVALID & AWREADY;
    assign w_hs       = WVALID & WREADY;
    assign b_hs       = BVALID & BREADY;
    assign final_beat = (beat_q == len_q);
    assign wlast_bad  = (WLAST != final_beat);
    assign step       = {{(ADDR_BITS-1){1'b0}}, 1'b1} << size_q;

`ifdef WSLV_RANGE_CHECK_EN
    assign aw_oor = |AWADDR[ADDR_BITS-1:MEM_ADDR_BITS+2];
`else
    assign aw_oor = 1'b0;
`endif

    // Next-state logic: one burst in flight, walking address, data, response.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (aw_hs) next_state = DATA;
            DATA:    if (w_hs && final_beat) next_state = RESP;
            RESP:    if (b_hs) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; ready/valid flags are registered copies of the next state.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
        end else begin
            state   <= next_state;
            AWREADY <= (next_state == IDLE);
            WREADY  <= (next_state == DATA);
            BVALID  <= (next_state == RESP);
        end
    end

    // Burst context: captured on AW, then beat count, address and error tracking per beat.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q   <= '0;
            addr_q <= '0;
            len_q  <= '0;
            size_q <= '0;
            beat_q <= '0;
            incr_q <= 1'b0;
            ok_q   <= 1'b0;
            oor_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (aw_hs) begin
            id_q   <= AWID;
            addr_q <= AWADDR;
            len_q  <= AWLEN;
            size_q <= AWSIZE;
            beat_q <= '0;
            incr_q <= (AWBURST == 2'b01);
            ok_q   <= !AWBURST[1] && !aw_oor;
            oor_q  <= aw_oor;
            err_q  <= AWBURST[1];
        end else if (w_hs) begin
            beat_q <= beat_q + 4'd1;
            if (wlast_bad) err_q <= 1'b1;
            if (incr_q) addr_q <= addr_q + step;
        end
    end

    // Response fields are latched on the final beat so they stay stable while BVALID waits.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            BID   <= '0;
            BRESP <= 2'b00;
        end else if (w_hs && final_beat) begin
            BID <= id_q;
            if (oor_q)                  BRESP <= 2'b11;
            else if (err_q || wlast_bad) BRESP <= 2'b10;
            else                        BRESP <= 2'b00;
        end
    end

    assign mem_cs    = w_hs & ok_q;
    assign mem_we    = mem_cs ? WSTRB : '0;
    assign mem_addr  = addr_q[MEM_ADDR_BITS+1:2];
    assign mem_wdata = mem_cs ? WDATA : '0;

endmodule

// File: tb/tb_axi_write_slave.sv
// tb_axi_write_slave: directed table plus randomized bursts against a
// burst-level reference model. Honours WSLV_RANGE_CHECK_EN when defined.

module tb_axi_write_slave;

    logic        ACLK;
    logic        ARESETn;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        mem_cs;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    axi_write_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #300000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    typedef struct {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          mode;
        logic [15:0] strbs;
        int          bdelay;
        logic [1:0]  exp_bresp;
        logic        exp_wr;
    } vec_t;

    vec_t vecs[10];

    // ---------------- reference model (burst-level rules) ----------------
    function automatic logic out_of_range(input logic [31:0] a);
`ifdef WSLV_RANGE_CHECK_EN
        return a >= 32'h0001_0000;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] sz,
                                              input logic [1:0] bt, input int i);
        if (bt == 2'b01) return a + 32'(i) * (32'd1 << sz);
        return a;
    endfunction

    function automatic logic wlast_of(input int mode, input int i, input int len);
        if (mode == 0) return (i == len);
        if (mode == 1) return (i == len) || (i == 0);
        return 1'b0;
    endfunction

    function automatic logic model_writes(input logic [31:0] a, input logic [1:0] bt);
        return (bt == 2'b00 || bt == 2'b01) && !out_of_range(a);
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a, input logic [1:0] bt,
                                              input int len, input int mode);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i <= len; i++)
            if (wlast_of(mode, i, len) != (i == len)) bad = 1'b1;
        if (out_of_range(a)) return 2'b11;
        if (bt[1] || bad) return 2'b10;
        return 2'b00;
    endfunction

    // ---------------- checking and stimulus tasks ----------------
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_awready"}, AWREADY, 0);
        checkOutput({tag, "_wready"}, WREADY, 0);
        checkOutput({tag, "_bvalid"}, BVALID, 0);
        checkOutput({tag, "_bid"}, BID, 0);
        checkOutput({tag, "_bresp"}, BRESP, 0);
        checkOutput({tag, "_mem_cs"}, mem_cs, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        AWID = id; AWADDR = a; AWLEN = len; AWSIZE = sz; AWBURST = bt; AWVALID = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            if (AWREADY) break;
        end
        checkOutput("aw_accept", AWREADY, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bt,
                          input logic [3:0] len, input int mode, input logic [15:0] strbs,
                          input logic exp_wr, input int nbeats, input int gap_pct);
        logic [31:0] ba;
        logic [3:0]  st;
        logic [31:0] wd;
        for (int i = 0; i < nbeats; i++) begin
            if (gap_pct > 0 && i > 0 && $urandom_range(99) < gap_pct) begin
                WVALID = 1'b0;
                @(negedge ACLK);
                checkOutput("gap_wready", WREADY, 1);
                checkOutput("gap_mem_cs", mem_cs, 0);
                @(posedge ACLK); #1;
            end
            st = strbs[4*(i%4) +: 4];
            wd = $urandom;
            WVALID = 1'b1; WDATA = wd; WSTRB = st; WLAST = wlast_of(mode, i, int'(len));
            ba = beat_addr(a, sz, bt, i);
            @(negedge ACLK);
            checkOutput("beat_wready", WREADY, 1);
            checkOutput("beat_mem_cs", mem_cs, exp_wr);
            checkOutput("beat_mem_we", mem_we, exp_wr ? st : 4'h0);
            if (exp_wr) begin
                checkOutput("beat_mem_addr", mem_addr, ba[15:2]);
                checkOutput("beat_mem_wdata", mem_wdata, wd);
            end
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic recv_b(input logic [7:0] id, input logic [1:0] resp, input int delay);
        BREADY = (delay == 0);
        @(negedge ACLK);
        checkOutput("b_bvalid", BVALID, 1);
        checkOutput("b_wready_low", WREADY, 0);
        checkOutput("b_bid", BID, id);
        checkOutput("b_bresp", BRESP, resp);
        for (int d = 1; d <= delay; d++) begin
            @(posedge ACLK); #1;
            if (d == delay) BREADY = 1'b1;
            @(negedge ACLK);
            checkOutput("stall_bvalid", BVALID, 1);
            checkOutput("stall_bid", BID, id);
            checkOutput("stall_bresp", BRESP, resp);
            checkOutput("stall_awready", AWREADY, 0);
        end
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        checkOutput("post_b_bvalid", BVALID, 0);
        checkOutput("post_b_awready", AWREADY, 1);
        @(posedge ACLK); #1;
    endtask

    task automatic applyStimulus(input vec_t v, input int gap_pct);
        send_aw(v.id, v.addr, v.len, v.size, v.burst);
        send_w(v.addr, v.size, v.burst, v.len, v.mode, v.strbs, v.exp_wr, int'(v.len) + 1, gap_pct);
        recv_b(v.id, v.exp_bresp, v.bdelay);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t rv;
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;

        //          id     addr           len size burst mode strbs     bd resp   wr
        vecs[0] = '{8'h15, 32'h0000_0010, 4'd0, 3'd2, 2'b01, 0, 16'h000F, 0, 2'b00, 1'b1};
        vecs[1] = '{8'h21, 32'h0000_0100, 4'd3, 3'd2, 2'b01, 0, 16'hFFFF, 0, 2'b00, 1'b1};
        vecs[2] = '{8'h33, 32'h0000_0020, 4'd2, 3'd2, 2'b00, 0, 16'h0C21, 1, 2'b00, 1'b1};
        vecs[3] = '{8'h44, 32'h0000_0040, 4'd1, 3'd2, 2'b01, 1, 16'h00FF, 0, 2'b10, 1'b1};
        vecs[4] = '{8'h55, 32'h0000_0080, 4'd3, 3'd2, 2'b10, 0, 16'hFFFF, 2, 2'b10, 1'b0};
        vecs[5] = '{8'h66, 32'h0000_0030, 4'd0, 3'd2, 2'b01, 0, 16'h0000, 0, 2'b00, 1'b1};
        vecs[6] = '{8'h77, 32'h0000_0200, 4'd2, 3'd2, 2'b01, 2, 16'h0FFF, 0, 2'b10, 1'b1};
        vecs[9] = '{8'hAA, 32'h0000_0003, 4'd1, 3'd0, 2'b11, 0, 16'h00FF, 0, 2'b10, 1'b0};
`ifdef WSLV_RANGE_CHECK_EN
        vecs[7] = '{8'h88, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01, 0, 16'h00FF, 0, 2'b11, 1'b0};
        vecs[8] = '{8'h99, 32'h0001_0000, 4'd0, 3'd2, 2'b01, 0, 16'h000F, 0, 2'b11, 1'b0};
`else
        vecs[7] = '{8'h88, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01, 0, 16'h00FF, 0, 2'b00, 1'b1};
        vecs[8] = '{8'h99, 32'h0001_0000, 4'd0, 3'd2, 2'b01, 0, 16'h000F, 0, 2'b00, 1'b1};
`endif

        // reset state and AWREADY rising one edge after release
        #12;
        @(negedge ACLK);
        check_all_zero("reset");
        @(posedge ACLK); #2;
        ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput("release_awready_early", AWREADY, 0);
        @(negedge ACLK);
        checkOutput("release_awready", AWREADY, 1);
        @(posedge ACLK); #1;

        $display("[TB] directed table");
        for (int k = 0; k < 10; k++) applyStimulus(vecs[k], 0);

        // B stalled five cycles with a new AW already pending
        $display("[TB] pending AW during B stall");
        send_aw(8'hC1, 32'h0000_0400, 4'd0, 3'd2, 2'b01);
        send_w(32'h0000_0400, 3'd2, 2'b01, 4'd0, 0, 16'h000F, 1'b1, 1, 0);
        BREADY = 1'b0;
        AWVALID = 1'b1; AWID = 8'hC2; AWADDR = 32'h0000_0404; AWLEN = 4'd0;
        AWSIZE = 3'd2; AWBURST = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            checkOutput("hold_bvalid", BVALID, 1);
            checkOutput("hold_bid", BID, 8'hC1);
            checkOutput("hold_bresp", BRESP, 2'b00);
            checkOutput("hold_awready", AWREADY, 0);
            @(posedge ACLK); #1;
            if (k == 4) BREADY = 1'b1;
        end
        @(negedge ACLK);
        checkOutput("hold_bvalid_last", BVALID, 1);
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        @(negedge ACLK);
        checkOutput("pend_bvalid_low", BVALID, 0);
        checkOutput("pend_awready", AWREADY, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        send_w(32'h0000_0404, 3'd2, 2'b01, 4'd0, 0, 16'h0003, 1'b1, 1, 0);
        recv_b(8'hC2, 2'b00, 0);

        // reset asserted after 2 of 4 beats
        $display("[TB] reset mid-burst");
        send_aw(8'hD1, 32'h0000_0500, 4'd3, 3'd2, 2'b01);
        send_w(32'h0000_0500, 3'd2, 2'b01, 4'd3, 0, 16'hFFFF, 1'b1, 2, 0);
        WVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WLAST = 1'b0;
        #2;
        ARESETn = 1'b0;
        @(negedge ACLK);
        check_all_zero("midreset");
        @(posedge ACLK); #2;
        ARESETn = 1'b1;
        WVALID = 1'b0;
        @(negedge ACLK);
        checkOutput("rel2_awready_early", AWREADY, 0);
        @(negedge ACLK);
        checkOutput("rel2_awready", AWREADY, 1);
        checkOutput("rel2_bvalid", BVALID, 0);
        @(negedge ACLK);
        checkOutput("rel2_bvalid_later", BVALID, 0);
        @(posedge ACLK); #1;
        applyStimulus(vecs[1], 0);

        // randomized bursts checked against the model
        $display("[TB] random bursts");
        for (int r = 0; r < 40; r++) begin
            rv.id    = 8'($urandom);
            rv.addr  = ($urandom_range(3) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_FFFF);
            rv.len   = 4'($urandom);
            rv.size  = 3'($urandom_range(3));
            rv.burst = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b01;
            rv.mode  = ($urandom_range(4) == 0) ? int'($urandom_range(1, 2)) : 0;
            rv.strbs = 16'($urandom);
            rv.bdelay = int'($urandom_range(3));
            rv.exp_bresp = model_resp(rv.addr, rv.burst, int'(rv.len), rv.mode);
            rv.exp_wr    = model_writes(rv.addr, rv.burst);
            applyStimulus(rv, 25);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
